// File: rtl/fwd_hazard_if.sv
// fwd_hazard_if: ID-stage request fields in, EX bypass selects and decode stall out
interface fwd_hazard_if #(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [REG_AW-1:0]         id_rd;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      flush;
    logic                      pipe_hold;
    logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel;
    logic                      stall;
    logic [15:0]               stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_mem_read, flush, pipe_hold,
        input  ex_fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_mem_read, flush, pipe_hold,
        output ex_fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand bypass selects, load-use decode stall and saturating stall counter
module fwd_hazard_unit #(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
    input logic         clk,
    input logic         arst_n,
    fwd_hazard_if.slave bus
);
    logic [FWD_DEPTH:0]             vld_q, vld_d, wr_q, wr_d, ld_q, ld_d, writer;
    logic [FWD_DEPTH:0][REG_AW-1:0] rd_q, rd_d;
    logic [NUM_SRC-1:0][REG_AW-1:0] rs_q, rs_d, id_rs;
    logic [NUM_SRC-1:0]             used_q, used_d;
    logic [NUM_SRC-1:0][SEL_W-1:0]  sel;
    logic [15:0]                    cnt_q, cnt_d;
    logic                           stall, take;

    assign id_rs = bus.id_rs;

    always_comb begin
        writer = '0;
        for (int k = 0; k <= FWD_DEPTH; k++)
            writer[k] = vld_q[k] && wr_q[k] && rd_q[k] != '0;
    end

    // Scan oldest to youngest so the lowest matching stage is the one left standing
    always_comb begin
        sel = '0;
        for (int j = 0; j < NUM_SRC; j++)
            for (int k = FWD_DEPTH; k >= 1; k--)
                if (vld_q[0] && used_q[j] && writer[k] && rd_q[k] == rs_q[j])
                    sel[j] = SEL_W'(k);
    end

    always_comb begin
        stall = 1'b0;
        for (int j = 0; j < NUM_SRC; j++)
            for (int s = 0; s < LOAD_LAT; s++)
                if (bus.id_valid && bus.id_rs_used[j] && writer[s] && ld_q[s] && rd_q[s] == id_rs[j])
                    stall = 1'b1;
    end

    assign take = bus.id_valid && !stall && !bus.flush;

    // A hold freezes every stage, but a flush may still kill whatever sits in EX
    always_comb begin
        vld_d  = bus.pipe_hold ? {vld_q[FWD_DEPTH:1], vld_q[0] && !bus.flush}
                               : {vld_q[FWD_DEPTH-1:0], take};
        wr_d   = bus.pipe_hold ? wr_q : {wr_q[FWD_DEPTH-1:0], bus.id_reg_write};
        ld_d   = bus.pipe_hold ? ld_q : {ld_q[FWD_DEPTH-1:0], bus.id_mem_read};
        rd_d   = bus.pipe_hold ? rd_q : {rd_q[FWD_DEPTH-1:0], bus.id_rd};
        rs_d   = bus.pipe_hold ? rs_q : id_rs;
        used_d = bus.pipe_hold ? used_q : bus.id_rs_used;
        cnt_d  = (stall && !bus.pipe_hold && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            vld_q  <= '0;
            wr_q   <= '0;
            ld_q   <= '0;
            rd_q   <= '0;
            rs_q   <= '0;
            used_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            wr_q   <= wr_d;
            ld_q   <= ld_d;
            rd_q   <= rd_d;
            rs_q   <= rs_d;
            used_q <= used_d;
            cnt_q  <= cnt_d;
        end

    assign bus.ex_fwd_sel = sel;
    assign bus.stall      = stall;
    assign bus.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed scoreboard bench over a depth-2/lat-1 and a depth-3/lat-2 unit
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_if #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2)) a ();
    fwd_hazard_if #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(3)) b ();

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_LAT(1)) dut_a (
        .clk(clk), .arst_n(arst_n), .bus(a)
    );
    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(3), .LOAD_LAT(2)) dut_b (
        .clk(clk), .arst_n(arst_n), .bus(b)
    );

    typedef struct {
        bit          d;
        logic [3:0]  sel;
        logic        stl;
        logic [15:0] cnt;
        string       nm;
    } exp_t;

    exp_t q[$];

    // Drive one cycle of stimulus into unit d (the other sits idle) and queue what it must show
    task automatic cyc(input string nm, input bit d, input bit v, input int r0, input int r1,
                       input bit [1:0] u, input int rd, input bit w, input bit ld, input bit fl,
                       input bit hd, input int s0, input int s1, input bit st, input int cn);
        exp_t       e;
        logic [9:0] rs;
        @(posedge clk);
        #1;
        rs = {5'(r1), 5'(r0)};
        a.id_valid     = !d && v;
        b.id_valid     = d && v;
        a.id_rs        = d ? 10'd0 : rs;
        b.id_rs        = d ? rs : 10'd0;
        a.id_rs_used   = d ? 2'b00 : u;
        b.id_rs_used   = d ? u : 2'b00;
        a.id_rd        = d ? 5'd0 : 5'(rd);
        b.id_rd        = d ? 5'(rd) : 5'd0;
        a.id_reg_write = !d && w;
        b.id_reg_write = d && w;
        a.id_mem_read  = !d && ld;
        b.id_mem_read  = d && ld;
        a.flush        = !d && fl;
        b.flush        = d && fl;
        a.pipe_hold    = !d && hd;
        b.pipe_hold    = d && hd;
        e.d   = d;
        e.sel = {2'(s1), 2'(s0)};
        e.stl = st;
        e.cnt = 16'(cn);
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic nop(input string nm, input bit d, input int s0, input int s1, input bit st, input int cn);
        cyc(nm, d, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, s0, s1, st, cn);
    endtask

    exp_t        m;
    logic [3:0]  got_sel;
    logic        got_stl;
    logic [15:0] got_cnt;

    initial forever begin
        @(negedge clk);
        if (q.size() != 0) begin
            m       = q.pop_front();
            got_sel = m.d ? b.ex_fwd_sel : a.ex_fwd_sel;
            got_stl = m.d ? b.stall : a.stall;
            got_cnt = m.d ? b.stall_cnt : a.stall_cnt;
            checks++;
            if (got_sel !== m.sel) begin
                errors++;
                $display("FAIL %s ex_fwd_sel: got %h want %h", m.nm, got_sel, m.sel);
            end
            checks++;
            if (got_stl !== m.stl) begin
                errors++;
                $display("FAIL %s stall: got %b want %b", m.nm, got_stl, m.stl);
            end
            checks++;
            if (got_cnt !== m.cnt) begin
                errors++;
                $display("FAIL %s stall_cnt: got %0d want %0d", m.nm, got_cnt, m.cnt);
            end
        end
    end

    initial begin
        // reset with a live load in ID; the last reset cycle goes idle so nothing is captured on release
        cyc("rst0", 0, 1, 3, 3, 2'b11, 3, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc("rst1", 0, 1, 3, 3, 2'b11, 3, 1, 1, 1, 0, 0, 0, 0, 0);
        nop("rst2", 1, 0, 0, 0, 0);
        @(negedge clk);
        #1 arst_n = 1'b1;
        // EX/MEM then MEM/WB forwarding
        cyc("add5",   0, 1, 1, 2, 2'b11, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("sub6",   0, 1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        nop("exmem",  0, 1, 1, 0, 0);
        nop("bub",    0, 0, 0, 0, 0);
        cyc("add5b",  0, 1, 1, 2, 2'b11, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        nop("gap",    0, 0, 0, 0, 0);
        cyc("sub6b",  0, 1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        nop("memwb",  0, 2, 2, 0, 0);
        // youngest writer wins
        cyc("w7a",    0, 1, 1, 2, 2'b11, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("w7b",    0, 1, 1, 2, 2'b11, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("rd7",    0, 1, 7, 6, 2'b11, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        nop("young",  0, 1, 0, 0, 0);
        // load-use
        cyc("lw3",      0, 1, 1, 0, 2'b01, 3, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc("lu_stall", 0, 1, 3, 0, 2'b11, 4, 1, 0, 0, 0, 0, 0, 1, 0);
        cyc("lu_clear", 0, 1, 3, 0, 2'b11, 4, 1, 0, 0, 0, 0, 0, 0, 1);
        nop("lu_fwd",   0, 2, 0, 0, 1);
        // x0 and unused operands
        cyc("lw0",        0, 1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        cyc("rd0",        0, 1, 0, 0, 2'b11, 9, 1, 0, 0, 0, 0, 0, 0, 1);
        nop("x0_sel",     0, 0, 0, 0, 1);
        cyc("lw3c",       0, 1, 0, 0, 2'b00, 3, 1, 1, 0, 0, 0, 0, 0, 1);
        cyc("unused",     0, 1, 3, 3, 2'b00, 10, 1, 0, 0, 0, 0, 0, 0, 1);
        nop("unused_sel", 0, 0, 0, 0, 1);
        // hold during a load-use stall
        cyc("lw3d", 0, 1, 10, 0, 2'b01, 3, 1, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            cyc("hold", 0, 1, 3, 3, 2'b11, 4, 1, 0, 0, 1, 2, 0, 1, 1);
        cyc("hold_rel", 0, 1, 3, 3, 2'b11, 4, 1, 0, 0, 0, 2, 0, 1, 1);
        cyc("after",    0, 1, 3, 3, 2'b11, 4, 1, 0, 0, 0, 0, 0, 0, 2);
        nop("fwd_hold", 0, 2, 2, 0, 2);
        // flush, alone and together with hold
        cyc("flush",      0, 1, 4, 4, 2'b11, 12, 1, 0, 1, 0, 0, 0, 0, 2);
        nop("flushed",    0, 0, 0, 0, 2);
        cyc("w11",        0, 1, 1, 2, 2'b11, 11, 1, 0, 0, 0, 0, 0, 0, 2);
        cyc("rd11",       0, 1, 11, 11, 2'b11, 12, 1, 0, 0, 0, 0, 0, 0, 2);
        cyc("hold_flush", 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 1, 1, 0, 2);
        nop("hf_after",   0, 0, 0, 0, 2);
        // depth 3, two-cycle load latency
        cyc("b_lw3",   1, 1, 0, 0, 2'b00, 3, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc("b_st1",   1, 1, 3, 0, 2'b11, 4, 1, 0, 0, 0, 0, 0, 1, 0);
        cyc("b_st2",   1, 1, 3, 0, 2'b11, 4, 1, 0, 0, 0, 0, 0, 1, 1);
        cyc("b_go",    1, 1, 3, 0, 2'b11, 4, 1, 0, 0, 0, 0, 0, 0, 2);
        nop("b_fwd3",  1, 3, 0, 0, 2);
        nop("b_bub",   1, 0, 0, 0, 2);
        cyc("b_lw3b",  1, 1, 0, 0, 2'b00, 3, 1, 1, 0, 0, 0, 0, 0, 2);
        cyc("b_indep", 1, 1, 1, 2, 2'b11, 9, 1, 0, 0, 0, 0, 0, 0, 2);
        cyc("b_st_s1", 1, 1, 3, 0, 2'b11, 4, 1, 0, 0, 0, 0, 0, 1, 2);
        cyc("b_go2",   1, 1, 3, 0, 2'b11, 4, 1, 0, 0, 0, 0, 0, 0, 3);
        nop("b_fwd3b", 1, 3, 0, 0, 3);
        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
